// File: rtl/bp_be_pkg.sv
// Shared types for the long-latency iterative divider.
//   bp_be_long_op_e    : operation select (DIV, DIVU, REM, REMU)
//   bp_be_long_state_e : divider control states
package bp_be_pkg;

   typedef enum logic [1:0] {
      e_div  = 2'd0,
      e_divu = 2'd1,
      e_rem  = 2'd2,
      e_remu = 2'd3
   } bp_be_long_op_e;

   typedef enum logic [1:0] {
      e_idle = 2'd0,
      e_calc = 2'd1,
      e_done = 2'd2
   } bp_be_long_state_e;

endpackage

// File: rtl/bp_be_long_iter_div_if.sv
// Request / response bundle of the iterative divider.
//   request : v_i, ready_o, op_i, word_i, a_i, b_i, tag_i, flush_i
//   response: v_o, data_o, tag_o, divz_o, yumi_i
// master = requester/consumer side, slave = divider side.
interface bp_be_long_iter_div_if
   import bp_be_pkg::*;
 #(parameter int width_p     = 64,
   parameter int tag_width_p = 5);

   logic                   v_i;
   logic                   ready_o;
   bp_be_long_op_e         op_i;
   logic                   word_i;
   logic [width_p-1:0]     a_i;
   logic [width_p-1:0]     b_i;
   logic [tag_width_p-1:0] tag_i;
   logic                   flush_i;

   logic                   v_o;
   logic [width_p-1:0]     data_o;
   logic [tag_width_p-1:0] tag_o;
   logic                   divz_o;
   logic                   yumi_i;

   modport master (
      output v_i, op_i, word_i, a_i, b_i, tag_i, flush_i, yumi_i,
      input  ready_o, v_o, data_o, tag_o, divz_o
   );

   modport slave (
      input  v_i, op_i, word_i, a_i, b_i, tag_i, flush_i, yumi_i,
      output ready_o, v_o, data_o, tag_o, divz_o
   );

endinterface

// File: rtl/bp_be_long_iter_div_fifo.sv
// Result buffer: circular FIFO of els_p entries.
//   v_i/data_i   : push (caller guarantees not full)
//   yumi_i       : pop head (ignored when empty)
//   v_o/data_o   : head entry; data_o reads zero when empty
//   full_o       : occupancy == els_p
// A push and a pop in the same cycle both take effect.
module bp_be_long_iter_div_fifo
 #(parameter int els_p        = 2,
   parameter int data_width_p = 8)
  (input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic                    v_i,
   input  logic [data_width_p-1:0] data_i,
   input  logic                    yumi_i,
   output logic                    v_o,
   output logic [data_width_p-1:0] data_o,
   output logic                    full_o);

   localparam int pw_lp = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int cw_lp = $clog2(els_p + 1);

   logic [els_p-1:0][data_width_p-1:0] mem_r;
   logic [pw_lp-1:0]                   rd_r, wr_r;
   logic [cw_lp-1:0]                   cnt_r;
   logic                               pop;

   function automatic logic [pw_lp-1:0] ptr_inc(input logic [pw_lp-1:0] p);
      return (p == pw_lp'(els_p - 1)) ? '0 : p + pw_lp'(1);
   endfunction

   assign v_o    = (cnt_r != '0);
   assign full_o = (cnt_r == cw_lp'(els_p));
   assign pop    = yumi_i & v_o;
   assign data_o = v_o ? mem_r[rd_r] : '0;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         mem_r <= '0;
         rd_r  <= '0;
         wr_r  <= '0;
         cnt_r <= '0;
      end else begin
         if (v_i) begin
            mem_r[wr_r] <= data_i;
            wr_r        <= ptr_inc(wr_r);
         end
         if (pop) rd_r <= ptr_inc(rd_r);
         cnt_r <= cnt_r + cw_lp'(v_i) - cw_lp'(pop);
      end
   end

endmodule

// File: rtl/bp_be_long_iter_div.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU, optional 32-bit word mode)
// with an els_p-deep result FIFO.
//   clk_i, reset_n_i : clock, async active-low reset
//   io (slave)       : request handshake v_i/ready_o, op_i, word_i, a_i, b_i,
//                      tag_i, flush_i; response v_o/yumi_i, data_o, tag_o, divz_o
// Latency accept -> v_o is N+2 cycles (N = width_p, or width_p/2 in word mode).
// Build option BP_BE_LONG_DIV_EARLY_OUT_EN: a zero divisor bypasses CALC and
// the result appears 2 cycles after accept.
module bp_be_long_iter_div
   import bp_be_pkg::*;
 #(parameter int width_p     = 64,
   parameter int els_p       = 2,
   parameter int tag_width_p = 5)
  (input logic                   clk_i,
   input logic                   reset_n_i,
   bp_be_long_iter_div_if.slave  io);

   localparam int hw_lp = width_p / 2;
   localparam int cw_lp = $clog2(width_p);
   localparam int fw_lp = width_p + tag_width_p + 1;

   bp_be_long_state_e      state_r;
   logic [cw_lp-1:0]       cnt_r;
   logic [width_p-1:0]     rem_r, quo_r, dvs_r;
   logic                   is_rem_r, word_r, q_neg_r, r_neg_r, divz_r;
   logic [tag_width_p-1:0] tag_r;

   logic                   signed_op, sa, sb, b_zero, accept, push, fifo_full, qbit;
   logic [width_p-1:0]     a_ext, b_ext, a_mag, b_mag, a_load;
   logic [width_p-1:0]     q_fix, r_fix, res, res_ext;
   logic [width_p:0]       sh, diff;
   logic [fw_lp-1:0]       fifo_data;

   // Operand conditioning: narrow to the low half in word mode, then magnitude.
   assign signed_op = ~io.op_i[0];

   always_comb begin
      a_ext = io.a_i;
      b_ext = io.b_i;
      if (io.word_i) begin
         a_ext = {{hw_lp{signed_op & io.a_i[hw_lp-1]}}, io.a_i[hw_lp-1:0]};
         b_ext = {{hw_lp{signed_op & io.b_i[hw_lp-1]}}, io.b_i[hw_lp-1:0]};
      end
   end

   assign sa     = signed_op & a_ext[width_p-1];
   assign sb     = signed_op & b_ext[width_p-1];
   assign a_mag  = sa ? -a_ext : a_ext;
   assign b_mag  = sb ? -b_ext : b_ext;
   assign b_zero = (b_ext == '0);
   // Word-mode dividend sits in the upper half so every step shifts from the MSB.
   assign a_load = io.word_i ? {a_mag[hw_lp-1:0], {hw_lp{1'b0}}} : a_mag;

   assign io.ready_o = (state_r == e_idle) & ~fifo_full & ~io.flush_i;
   assign accept     = io.v_i & io.ready_o;

   // One restoring step; remainder stays below the divisor so width_p bits suffice.
   assign sh   = {rem_r, quo_r[width_p-1]};
   assign diff = sh - {1'b0, dvs_r};
   assign qbit = ~diff[width_p];

   // Zero divisor leaves rem = |a|, so only the quotient needs overriding.
   assign q_fix   = divz_r ? '1 : (q_neg_r ? -quo_r : quo_r);
   assign r_fix   = r_neg_r ? -rem_r : rem_r;
   assign res     = is_rem_r ? r_fix : q_fix;
   assign res_ext = word_r ? {{hw_lp{res[hw_lp-1]}}, res[hw_lp-1:0]} : res;
   assign push    = (state_r == e_done) & ~io.flush_i;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r  <= e_idle;
         cnt_r    <= '0;
         rem_r    <= '0;
         quo_r    <= '0;
         dvs_r    <= '0;
         is_rem_r <= 1'b0;
         word_r   <= 1'b0;
         q_neg_r  <= 1'b0;
         r_neg_r  <= 1'b0;
         divz_r   <= 1'b0;
         tag_r    <= '0;
      end else begin
         case (state_r)
            e_idle: if (accept) begin
               is_rem_r <= io.op_i[1];
               word_r   <= io.word_i;
               tag_r    <= io.tag_i;
               q_neg_r  <= sa ^ sb;
               r_neg_r  <= sa;
               divz_r   <= b_zero;
               dvs_r    <= b_mag;
               quo_r    <= a_load;
               rem_r    <= '0;
               cnt_r    <= io.word_i ? cw_lp'(hw_lp - 1) : cw_lp'(width_p - 1);
               state_r  <= e_calc;
`ifdef BP_BE_LONG_DIV_EARLY_OUT_EN
               if (b_zero) begin
                  rem_r   <= a_mag;
                  state_r <= e_done;
               end
`endif
            end
            e_calc: begin
               if (io.flush_i) begin
                  state_r <= e_idle;
               end else begin
                  rem_r <= qbit ? diff[width_p-1:0] : sh[width_p-1:0];
                  quo_r <= {quo_r[width_p-2:0], qbit};
                  if (cnt_r == '0) state_r <= e_done;
                  else             cnt_r   <= cnt_r - cw_lp'(1);
               end
            end
            e_done:  state_r <= e_idle;
            default: state_r <= e_idle;
         endcase
      end
   end

   bp_be_long_iter_div_fifo #(
      .els_p        (els_p),
      .data_width_p (fw_lp)
   ) fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .v_i       (push),
      .data_i    ({divz_r, tag_r, res_ext}),
      .yumi_i    (io.yumi_i),
      .v_o       (io.v_o),
      .data_o    (fifo_data),
      .full_o    (fifo_full)
   );

   assign {io.divz_o, io.tag_o, io.data_o} = fifo_data;

endmodule

// File: tb/tb_bp_be_long_iter_div.sv
// Scoreboard bench for bp_be_long_iter_div (width_p=64, els_p=2, tag 5 bits).
module tb_bp_be_long_iter_div;
   import bp_be_pkg::*;

   localparam int W = 64;
`ifdef BP_BE_LONG_DIV_EARLY_OUT_EN
   localparam int divz_lat_d = 2;
   localparam int divz_lat_w = 2;
`else
   localparam int divz_lat_d = 66;
   localparam int divz_lat_w = 34;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bp_be_long_iter_div_if #(.width_p(W), .tag_width_p(5)) io();

   bp_be_long_iter_div #(.width_p(W), .els_p(2), .tag_width_p(5)) dut (
      .clk_i     (clk),
      .reset_n_i (rst_n),
      .io        (io)
   );

   typedef struct {
      logic [W-1:0] data;
      logic [4:0]   tag;
      logic         divz;
      int           exp_cyc;
   } exp_t;

   exp_t sb_q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   first_cyc = 0;
   bit   hold = 1'b0;
   bit   seen = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops the head whenever the consumer is not holding off.
   initial begin
      exp_t e;
      io.yumi_i = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            seen = 1'b0;
         end else if (io.v_o) begin
            if (!seen) begin
               seen      = 1'b1;
               first_cyc = cyc;
            end
            if (!hold) begin
               if (sb_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected result: data %h tag %0d", io.data_o, io.tag_o);
               end else begin
                  e = sb_q.pop_front();
                  check($sformatf("data tag%0d", e.tag), io.data_o, e.data);
                  check($sformatf("tag tag%0d", e.tag), W'(io.tag_o), W'(e.tag));
                  check($sformatf("divz tag%0d", e.tag), W'(io.divz_o), W'(e.divz));
                  if (e.exp_cyc >= 0)
                     check($sformatf("latency tag%0d", e.tag), W'(first_cyc), W'(e.exp_cyc));
               end
               io.yumi_i = 1'b1;
               @(posedge clk);
               #1 io.yumi_i = 1'b0;
               seen = 1'b0;
            end
         end
      end
   end

   task automatic issue(input bp_be_long_op_e op, input logic word, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [4:0] tag, input logic [W-1:0] exp_d,
                        input logic exp_z, input int lat, input bit expect_it);
      int waited = 0;
      @(negedge clk);
      io.v_i = 1'b1; io.op_i = op; io.word_i = word;
      io.a_i = a; io.b_i = b; io.tag_i = tag;
      #1;
      while (!io.ready_o && waited < 400) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (!io.ready_o) begin
         tests++;
         fails++;
         $display("FAIL accept tag%0d: ready_o stayed 0, required 1", tag);
         io.v_i = 1'b0;
         return;
      end
      if (expect_it) sb_q.push_back('{exp_d, tag, exp_z, (lat >= 0) ? cyc + lat : -1});
      @(posedge clk);
      #1 io.v_i = 1'b0;
   endtask

   task automatic drain();
      int w = 0;
      while (sb_q.size() != 0 && w < 400) begin
         @(negedge clk);
         w++;
      end
      check("drain queue empty", W'(sb_q.size()), '0);
   endtask

   initial begin
      #200000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int w;
      io.v_i = 1'b0; io.op_i = e_div; io.word_i = 1'b0;
      io.a_i = '0; io.b_i = '0; io.tag_i = '0; io.flush_i = 1'b0;

      #12;
      check("reset v_o", W'(io.v_o), '0);
      check("reset data_o", io.data_o, '0);
      check("reset tag_o", W'(io.tag_o), '0);
      check("reset divz_o", W'(io.divz_o), '0);
      rst_n = 1'b1;
      @(negedge clk);
      #1 check("ready after reset", W'(io.ready_o), 64'd1);

      // Directed vectors
      issue(e_divu, 0, 64'd100, 64'd7, 5'd1, 64'd14, 0, 66, 1);
      issue(e_rem,  0, -64'sd7, 64'd2, 5'd2, -64'sd1, 0, 66, 1);
      issue(e_div,  0, 64'h8000_0000_0000_0000, '1, 5'd3, 64'h8000_0000_0000_0000, 0, 66, 1);
      issue(e_divu, 1, 64'h0000_0000_FFFF_FFFF, 64'd1, 5'd4, '1, 0, 34, 1);
      issue(e_div,  0, 64'd5, 64'd0, 5'd5, '1, 1, divz_lat_d, 1);
      issue(e_remu, 0, 64'd5, 64'd0, 5'd6, 64'd5, 1, divz_lat_d, 1);
      issue(e_div,  0, -64'sd100, 64'd7, 5'd7, 64'hFFFF_FFFF_FFFF_FFF2, 0, 66, 1);
      issue(e_rem,  0, -64'sd100, 64'd7, 5'd8, 64'hFFFF_FFFF_FFFF_FFFE, 0, 66, 1);
      issue(e_div,  1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 5'd9,
            64'hFFFF_FFFF_FFFF_FFFD, 0, 34, 1);
      issue(e_remu, 1, 64'h0000_0001_0000_0064, 64'd7, 5'd10, 64'd2, 0, 34, 1);
      issue(e_div,  1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd11,
            64'hFFFF_FFFF_8000_0000, 0, 34, 1);
      issue(e_remu, 1, 64'h0000_0000_8000_0005, 64'hFFFF_FFFF_0000_0000, 5'd12,
            64'hFFFF_FFFF_8000_0005, 1, divz_lat_w, 1);
      issue(e_divu, 0, '1, '1, 5'd13, 64'd1, 0, 66, 1);
      issue(e_rem,  0, 64'h8000_0000_0000_0000, '1, 5'd14, 64'd0, 0, 66, 1);
      drain();

      // Buffer full: third request waits for a pop; order and tags kept.
      hold = 1'b1;
      issue(e_divu, 0, 64'd50, 64'd5, 5'd20, 64'd10, 0, -1, 1);
      issue(e_divu, 0, 64'd60, 64'd5, 5'd21, 64'd12, 0, -1, 1);
      repeat (70) @(negedge clk);
      #2;
      check("full buffer ready_o", W'(io.ready_o), '0);
      check("full buffer v_o", W'(io.v_o), 64'd1);
      fork
         issue(e_divu, 0, 64'd70, 64'd5, 5'd22, 64'd14, 0, -1, 1);
         begin
            repeat (4) @(negedge clk);
            #2 check("third req blocked", W'(io.ready_o & io.v_i), '0);
            hold = 1'b0;
         end
      join
      drain();

      // Flush mid-CALC, then flush with a same-cycle request.
      @(negedge clk);
      io.v_i = 1'b1; io.op_i = e_divu; io.word_i = 1'b0;
      io.a_i = 64'd100; io.b_i = 64'd7; io.tag_i = 5'd30;
      @(posedge clk);
      #1 io.v_i = 1'b0;
      repeat (10) @(negedge clk);
      #1 check("ready_o in CALC", W'(io.ready_o), '0);
      io.flush_i = 1'b1;
      @(posedge clk);
      #1 io.flush_i = 1'b0;
      @(negedge clk);
      #1 check("ready_o after flush", W'(io.ready_o), 64'd1);
      io.v_i = 1'b1; io.flush_i = 1'b1; io.tag_i = 5'd31;
      #1 check("ready_o gated by flush", W'(io.ready_o), '0);
      @(posedge clk);
      #1 begin io.v_i = 1'b0; io.flush_i = 1'b0; end
      @(negedge clk);
      #1 check("flushed request dropped", W'(io.ready_o), 64'd1);
      repeat (80) @(negedge clk);
      check("no result after flush", W'(io.v_o), '0);

      // Reset with one buffered result and one operation in CALC.
      hold = 1'b1;
      issue(e_divu, 0, 64'd9, 64'd3, 5'd12, 64'd3, 0, -1, 0);
      w = 0;
      while (!io.v_o && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("v_o before reset", W'(io.v_o), 64'd1);
      issue(e_divu, 0, 64'd9, 64'd3, 5'd13, 64'd3, 0, -1, 0);
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("v_o at reset", W'(io.v_o), '0);
      check("data_o at reset", io.data_o, '0);
      check("tag_o at reset", W'(io.tag_o), '0);
      #5 rst_n = 1'b1;
      seen = 1'b0;
      hold = 1'b0;
      @(negedge clk);
      #1 check("ready_o after reset pulse", W'(io.ready_o), 64'd1);
      repeat (80) @(negedge clk);
      check("no result after reset", W'(io.v_o), '0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bp_be_long_iter_div.md
BP_BE_LONG_ITER_DIV -- requirements
Module: bp_be_long_iter_div

Interface
REQ-001 SHALL have parameter width_p, default 64, operand/result width (even, >=8).
REQ-002 SHALL have parameter els_p, default 2, output buffer depth (>=1).
REQ-003 SHALL have parameter tag_width_p, default 5, width of opaque destination tag.
REQ-004 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset_n_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port v_i  input  1  request valid.
REQ-007 SHALL have port ready_o  output  1  request accepted when v_i & ready_o.
REQ-008 SHALL have port op_i  input  2  0=DIV, 1=DIVU, 2=REM, 3=REMU.
REQ-009 SHALL have port word_i  input  1  operate on low width_p/2 bits; sign-extend result.
REQ-010 SHALL have ports a_i, b_i  input  width_p  dividend, divisor.
REQ-011 SHALL have port tag_i  input  tag_width_p  tag returned with result.
REQ-012 SHALL have port flush_i  input  1  kill in-flight operation.
REQ-013 SHALL have port v_o  output  1  result valid (buffer non-empty).
REQ-014 SHALL have ports data_o  output  width_p, tag_o  output  tag_width_p, divz_o  output  1  (divisor was zero).
REQ-015 SHALL have port yumi_i  input  1  consumer pops head; legal only when v_o.

Function
REQ-016 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE; ready_o = (state==IDLE) & (buffer occupancy < els_p).
REQ-017 On accept SHALL latch op, word, tag; take magnitudes of signed operands (op 0/2); record result sign: quotient = sa^sb, remainder = sa.
REQ-018 CALC SHALL run one restoring shift-subtract step per cycle for exactly N cycles, N = width_p (word_i=0) or width_p/2 (word_i=1).
REQ-019 DONE SHALL apply sign correction, select quotient/remainder, sign-extend from bit width_p/2-1 if word_i, push one entry to buffer.
REQ-020 Latency accept -> v_o SHALL be N+2 cycles with an empty buffer.
REQ-021 Divisor zero SHALL yield quotient all-ones, remainder = dividend (sign-extended if word), divz_o=1.
REQ-022 Signed overflow (min / -1) SHALL yield quotient = min, remainder 0, divz_o=0.
REQ-023 Buffer SHALL be FIFO, els_p entries; push and pop in the same cycle both take effect; a full buffer never blocks DONE (guaranteed by REQ-016).
REQ-024 flush_i SHALL force state to IDLE next cycle from CALC or DONE, with no push; buffered entries SHALL be unaffected.
REQ-025 flush_i with v_i same cycle SHALL drop the request (ready_o gated low by flush_i).
REQ-026 ready_o SHALL be low in CALC and DONE; back-to-back accepts possible in the cycle after DONE.

Reset
REQ-027 reset_n_i low SHALL asynchronously set state IDLE, buffer empty: v_o=0, ready_o=1 after release, data_o/tag_o/divz_o=0.
REQ-028 Reset mid-CALC SHALL discard the operation; no result ever emitted for it.

Configuration
REQ-029 Macro BP_BE_LONG_DIV_EARLY_OUT_EN defined: divisor zero detected at accept, skips CALC, result pushed 2 cycles after accept.
REQ-030 Macro undefined: divisor-zero takes full N+2 cycles; results per REQ-021 identical.

Structure
REQ-031 Op encoding enum (bp_be_long_op_e) SHALL live in bp_be_pkg.
REQ-032 Output buffer SHALL be a sub-module bp_be_long_iter_div_fifo (els_p, data+tag+flag width).

Verification
REQ-033 DIVU 64-bit a=100, b=7 -> data_o=14, v_o at cycle 66 after accept, divz_o=0.
REQ-034 REM a=-7, b=2 -> data_o=-1; DIV a=0x8000..0, b=-1 -> data_o=0x8000..0.
REQ-035 DIVU word_i=1 a=0x0000_0000_FFFF_FFFF, b=1 -> data_o=0xFFFF_FFFF_FFFF_FFFF (sign-extended), latency 34.
REQ-036 DIV b=0, a=5 -> data_o=all-ones, divz_o=1; latency 2 with macro, 66 without.
REQ-037 els_p=2, yumi_i held low, three requests -> third not accepted (ready_o=0) until one pop; order and tags preserved.
REQ-038 flush_i in cycle 10 of CALC -> no push, ready_o=1 next cycle; reset_n_i pulsed mid-CALC -> v_o=0 immediately.
